// File: rtl/bconv_pkg.sv
// Shared types and sizing helpers for the BConv feature-map reader.
package bconv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    localparam int unsigned DEF_OUTPUT_H = 26;
    localparam int unsigned DEF_OUTPUT_W = 26;

    function automatic int unsigned calc_nwords(input int unsigned h,
                                                input int unsigned w,
                                                input int unsigned ww);
        return (h * w + ww - 1) / ww;
    endfunction

endpackage

// File: rtl/bconv_popcount.sv
// Combinational count of set bits across the flat feature map.
module bconv_popcount #(
    parameter int unsigned N   = 676,
    parameter int unsigned CNT = 10
) (
    input  logic [N-1:0]   bits,
    output logic [CNT-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + CNT'(bits[i]);
        end
    end

endmodule

// File: rtl/bconv_fmap_reader.sv
// Snapshots the BConv output map and streams it as WORD_W-bit words over valid/ready.
// Define BCONV_READER_POPCOUNT_EN to append a popcount trailer word to each frame.
module bconv_fmap_reader
    import bconv_pkg::*;
#(
    parameter int unsigned OUTPUT_H = DEF_OUTPUT_H,
    parameter int unsigned OUTPUT_W = DEF_OUTPUT_W,
    parameter int unsigned WORD_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OUTPUT_H*OUTPUT_W-1:0] fmap_i,
    input  logic                         fmap_valid_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic [WORD_W-1:0]            m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         m_last_o
);

    localparam int unsigned NPIX   = OUTPUT_H * OUTPUT_W;
    localparam int unsigned NWORDS = calc_nwords(OUTPUT_H, OUTPUT_W, WORD_W);
    localparam int unsigned SNAP_W = NWORDS * WORD_W;
`ifdef BCONV_READER_POPCOUNT_EN
    localparam int unsigned FRAME_WORDS = NWORDS + 1;
    localparam int unsigned PC_W        = $clog2(NPIX + 1);
`else
    localparam int unsigned FRAME_WORDS = NWORDS;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);

    state_t             state, state_n;
    logic [SNAP_W-1:0]  snap;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   next_idx;
    logic [WORD_W-1:0]  sel_word;
    logic               load_snap, load_first, advance, finish;

`ifdef BCONV_READER_POPCOUNT_EN
    logic [PC_W-1:0] pc_comb, pcnt;

    bconv_popcount #(
        .N   (NPIX),
        .CNT (PC_W)
    ) u_popcount (
        .bits  (snap[NPIX-1:0]),
        .count (pc_comb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (load_first) begin
            pcnt <= pc_comb;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        load_snap  = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i && fmap_valid_i) begin
                    state_n   = LOAD;
                    load_snap = 1'b1;
                end
            end
            LOAD: begin
                state_n    = STREAM;
                load_first = 1'b1;
            end
            STREAM: begin
                if (m_valid_o && m_ready_i) begin
                    if (m_last_o) begin
                        state_n = IDLE;
                        finish  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Index of the word to present after this edge: 0 on LOAD, else the successor.
    assign next_idx = (state == LOAD) ? '0 : cnt + CNT_W'(1);

    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < NWORDS; k++) begin
            if (next_idx == CNT_W'(k)) begin
                sel_word = snap[k*WORD_W +: WORD_W];
            end
        end
`ifdef BCONV_READER_POPCOUNT_EN
        if (next_idx == CNT_W'(NWORDS)) begin
            sel_word = WORD_W'(pcnt);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap      <= '0;
            cnt       <= '0;
            busy_o    <= 1'b0;
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end else begin
            if (load_snap) begin
                snap   <= SNAP_W'(fmap_i);
                cnt    <= '0;
                busy_o <= 1'b1;
            end
            if (load_first || advance) begin
                cnt       <= next_idx;
                m_data_o  <= sel_word;
                m_valid_o <= 1'b1;
                m_last_o  <= (next_idx == CNT_W'(FRAME_WORDS - 1));
            end
            if (finish) begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
                m_data_o  <= '0;
                busy_o    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bconv_fmap_reader.sv
// Self-checking bench for bconv_fmap_reader; honours BCONV_READER_POPCOUNT_EN.
module tb_bconv_fmap_reader;

    localparam int H    = 26;
    localparam int W    = 26;
    localparam int WW   = 16;
    localparam int NPIX = H * W;
    localparam int NW   = (NPIX + WW - 1) / WW;
`ifdef BCONV_READER_POPCOUNT_EN
    localparam int FRAME = NW + 1;
`else
    localparam int FRAME = NW;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NPIX-1:0] fmap;
    logic            fmap_valid;
    logic            start;
    logic            busy;
    logic [WW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bconv_fmap_reader #(
        .OUTPUT_H (H),
        .OUTPUT_W (W),
        .WORD_W   (WW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fmap_i       (fmap),
        .fmap_valid_i (fmap_valid),
        .start_i      (start),
        .busy_o       (busy),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last)
    );

    typedef struct {
        logic [NPIX-1:0] map;
        int              mode;     // 0 ready always, 1 toggling, 2 random
        int              perturb;  // 0 none, 1 clear fmap, 2 start mid-frame, 3 reset at word 20, 4 start on last
        int              probe_idx;
        logic [WW-1:0]   probe_val;
        int              exp_n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: word k holds flat pixels k*WW .. k*WW+WW-1, zero past the map;
    // the optional trailer is the number of set pixels.
    function automatic logic [WW-1:0] model_word(input logic [NPIX-1:0] m, input int k);
        logic [WW-1:0] w;
        int ones;
        w = '0;
        ones = 0;
        if (k == NW) begin
            for (int i = 0; i < NPIX; i++) ones += int'(m[i]);
            return WW'(ones);
        end
        for (int j = 0; j < WW; j++) begin
            if (k * WW + j < NPIX) w[j] = m[k*WW + j];
        end
        return w;
    endfunction

    task automatic run_frame(input vec_t v, input int id);
        int n, cyc;
        bit done, stalled, did_start, rdy;
        logic [WW-1:0] held_data;
        logic held_last;
        string tag;
        tag = $sformatf("v%0d", id);

        fmap = v.map;
        fmap_valid = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        if (v.perturb == 1) fmap = '0;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        chk({tag, "_load_valid"}, 32'(m_valid), 32'd0);
        step;
        chk({tag, "_first_valid"}, 32'(m_valid), 32'd1);

        n = 0; cyc = 0; done = 0; stalled = 0; did_start = 0;
        held_data = '0; held_last = 1'b0;
        while (!done && cyc < 2000) begin
            if (v.perturb == 3 && n == 20) begin
                rst = 1'b1;
                step;
                rst = 1'b0;
                done = 1;
            end else begin
                case (v.mode)
                    0: rdy = 1;
                    1: rdy = (cyc % 2 == 0);
                    default: rdy = ($urandom_range(0, 2) != 0);
                endcase
                m_ready = rdy;
                start = 1'b0;
                if (v.perturb == 2 && n == 10 && !did_start) begin
                    start = 1'b1;
                    did_start = 1;
                end
                if (v.perturb == 4 && rdy && m_last) start = 1'b1;
                chk({tag, "_valid_held"}, 32'(m_valid), 32'd1);
                if (stalled) begin
                    chk({tag, "_stall_data"}, 32'(m_data), 32'(held_data));
                    chk({tag, "_stall_last"}, 32'(m_last), 32'(held_last));
                end
                if (rdy) begin
                    chk($sformatf("%s_word%0d", tag, n), 32'(m_data), 32'(model_word(v.map, n)));
                    chk($sformatf("%s_last%0d", tag, n), 32'(m_last), 32'(n == FRAME - 1));
                    if (n == v.probe_idx)
                        chk({tag, "_probe"}, 32'(m_data), 32'(v.probe_val));
                    if (m_last || n >= FRAME - 1) done = 1;
                    n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_data = m_data;
                    held_last = m_last;
                end
                step;
            end
            cyc++;
        end
        start = 1'b0;
        m_ready = 1'b0;
        if (!done) chk({tag, "_timeout"}, 32'(cyc), 32'd0);
        chk({tag, "_handshakes"}, 32'(n), 32'(v.exp_n));
        chk({tag, "_end_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_last"}, 32'(m_last), 32'd0);
        step;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_valid"}, 32'(m_valid), 32'd0);
    endtask

    vec_t vecs[10];
    logic [NPIX-1:0] m_alt, m_one, m_pix;

    initial begin
        rst = 1'b1; fmap = '0; fmap_valid = 1'b0; start = 1'b0; m_ready = 1'b0;

        for (int i = 0; i < NPIX; i++) m_alt[i] = (i % 2 == 0);
        m_one = '1;
        m_pix = '0;
        m_pix[1*W + 0] = 1'b1;

        vecs[0] = '{m_alt, 0, 0, 5,  16'h5555, FRAME};
        vecs[1] = '{m_alt, 0, 0, 42, 16'h0005, FRAME};
        vecs[2] = '{m_one, 1, 0, 42, 16'h000F, FRAME};
        vecs[3] = '{m_pix, 0, 0, 1,  16'h0400, FRAME};
        vecs[4] = '{m_alt, 2, 2, 10, 16'h5555, FRAME};
        vecs[5] = '{m_pix, 2, 1, 1,  16'h0400, FRAME};
        vecs[6] = '{m_one, 0, 3, 0,  16'hFFFF, 20};
`ifdef BCONV_READER_POPCOUNT_EN
        vecs[7] = '{m_one, 2, 4, NW, 16'h02A4, FRAME};
`else
        vecs[7] = '{m_one, 2, 4, 0,  16'hFFFF, FRAME};
`endif
        for (int r = 8; r < 10; r++) begin
            for (int i = 0; i < NPIX; i++) vecs[r].map[i] = 1'($urandom_range(0, 1));
            vecs[r].mode = 2;
            vecs[r].perturb = 0;
            vecs[r].probe_idx = -1;
            vecs[r].probe_val = '0;
            vecs[r].exp_n = FRAME;
        end

        step; step;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);

        // start without a valid map must be ignored
        fmap = m_one;
        start = 1'b1;
        step;
        start = 1'b0;
        chk("nostart_busy", 32'(busy), 32'd0);
        step; step;
        chk("nostart_busy2", 32'(busy), 32'd0);
        chk("nostart_valid", 32'(m_valid), 32'd0);

        for (int r = 0; r < 10; r++) run_frame(vecs[r], r);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
